// File: rtl/frame_aligner.sv
// Frame aligner: hunts for a periodic sync position in the detector mask, confirms it,
// then emits word-aligned data with a start-of-frame marker until sync is repeatedly missed.
module frame_aligner #(
  parameter int WIDTH       = 16,
  parameter int FRAME_WORDS = 8,
  parameter int CONFIRM     = 2,
  parameter int MISS_LIMIT  = 3
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [2*WIDTH-1:0]         sync_mask,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_sof,
  output logic                       locked,
  output logic [$clog2(WIDTH)-1:0]   phase,
  output logic                       lock_lost
);

  localparam int WCW = $clog2(FRAME_WORDS);
  localparam int HCW = $clog2(CONFIRM + 1);
  localparam int MCW = $clog2(MISS_LIMIT + 1);
  localparam int CIW = $clog2(2 * WIDTH);
  localparam int PW  = $clog2(WIDTH);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] window_q, window_d;
  logic               eval_q, eval_d;
  logic [WCW-1:0]     word_cnt_q, word_cnt_d;
  logic [CIW-1:0]     cap_idx_q, cap_idx_d;
  logic [HCW-1:0]     hit_cnt_q, hit_cnt_d;
  logic [MCW-1:0]     miss_cnt_q, miss_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_sof_q, out_sof_d;
  logic               locked_q, locked_d;
  logic               lock_lost_q, lock_lost_d;

  logic [CIW-1:0]     low_idx;
  logic [PW-1:0]      cur_phase;
  logic [WCW-1:0]     word_cnt_inc;
  logic               slot;
  logic               slot_hit;
  logic [HCW-1:0]     hit_inc;
  logic [MCW-1:0]     miss_inc;

  // Scanning from the top down leaves the lowest set mask index in low_idx.
  always_comb begin
    low_idx = '0;
    for (int i = 2*WIDTH-1; i >= 0; i--) begin
      if (sync_mask[i]) low_idx = CIW'(i);
    end
  end

  assign cur_phase    = (cap_idx_q >= CIW'(WIDTH)) ? PW'(cap_idx_q - CIW'(WIDTH)) : PW'(cap_idx_q);
  assign slot         = (word_cnt_q == WCW'(FRAME_WORDS - 1));
  assign word_cnt_inc = slot ? '0 : word_cnt_q + WCW'(1);
  assign slot_hit     = sync_mask[cap_idx_q];
  assign hit_inc      = hit_cnt_q + HCW'(1);
  assign miss_inc     = miss_cnt_q + MCW'(1);

  always_comb begin
    state_d     = state_q;
    window_d    = window_q;
    eval_d      = in_valid;
    word_cnt_d  = word_cnt_q;
    cap_idx_d   = cap_idx_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sof_d   = 1'b0;
    lock_lost_d = 1'b0;

    if (in_valid) window_d = {window_q[WIDTH-1:0], in_data};

    // sync_mask only means something on the cycle after a word was accepted.
    if (eval_q) begin
      case (state_q)
        HUNT: begin
          if (|sync_mask) begin
            cap_idx_d  = low_idx;
            word_cnt_d = '0;
            hit_cnt_d  = '0;
            state_d    = VERIFY;
          end
        end
        VERIFY: begin
          word_cnt_d = word_cnt_inc;
          if (slot) begin
            if (slot_hit) begin
              hit_cnt_d = hit_inc;
              if (hit_inc == HCW'(CONFIRM)) begin
                state_d    = LOCKED;
                miss_cnt_d = '0;
              end
            end else begin
              state_d = HUNT;
            end
          end
        end
        LOCKED: begin
          out_valid_d = 1'b1;
          out_data_d  = window_q[cur_phase +: WIDTH];
          out_sof_d   = (word_cnt_q == '0);
          word_cnt_d  = word_cnt_inc;
          if (slot) begin
            if (slot_hit) begin
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_inc;
              if (miss_inc == MCW'(MISS_LIMIT)) begin
                state_d     = HUNT;
                lock_lost_d = 1'b1;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= HUNT;
      window_q    <= '0;
      eval_q      <= 1'b0;
      word_cnt_q  <= '0;
      cap_idx_q   <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      window_q    <= window_d;
      eval_q      <= eval_d;
      word_cnt_q  <= word_cnt_d;
      cap_idx_q   <= cap_idx_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign locked    = locked_q;
  assign lock_lost = lock_lost_q;
  assign phase     = cur_phase;

endmodule

// File: tb/tb_frame_aligner.sv
// Randomized and directed bench for frame_aligner, checked every cycle against an
// event-level reference model of the hunt/verify/lock rules.
module tb_frame_aligner;

  localparam int W           = 8;
  localparam int FW          = 4;
  localparam int CONFIRM     = 2;
  localparam int MISS_LIMIT  = 2;
  localparam int M_HUNT      = 0;
  localparam int M_VERIFY    = 1;
  localparam int M_LOCKED    = 2;

  logic               clk = 1'b0;
  logic               nrst = 1'b0;
  logic               in_valid = 1'b0;
  logic [W-1:0]       in_data = '0;
  logic [2*W-1:0]     sync_mask = '0;
  logic               out_valid;
  logic [W-1:0]       out_data;
  logic               out_sof;
  logic               locked;
  logic [$clog2(W)-1:0] phase;
  logic               lock_lost;

  frame_aligner #(
    .WIDTH(W), .FRAME_WORDS(FW), .CONFIRM(CONFIRM), .MISS_LIMIT(MISS_LIMIT)
  ) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data),
    .sync_mask(sync_mask), .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .locked(locked), .phase(phase), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  int test_count = 0;
  int fail_count = 0;

  // Reference model state, advanced once per accepted-word evaluation.
  int           mode, wc, cap, hits, misses;
  bit           prev_valid;
  logic [W-1:0] hist[$];
  logic         exp_valid, exp_sof, exp_lost;
  logic [W-1:0] exp_data;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
    checkOutput("out_sof",   32'(out_sof),   32'(exp_sof));
    checkOutput("out_data",  32'(out_data),  32'(exp_data));
    checkOutput("locked",    32'(locked),    32'(mode == M_LOCKED));
    checkOutput("lock_lost", 32'(lock_lost), 32'(exp_lost));
    checkOutput("phase",     32'(phase),     32'(cap % W));
  endtask

  task automatic modelEval(input logic [2*W-1:0] m);
    logic [2*W-1:0] win;
    logic [2*W-1:0] shifted;
    win = '0;
    if (hist.size() == 2) win = {hist[0], hist[1]};
    else if (hist.size() == 1) win = {{W{1'b0}}, hist[0]};
    case (mode)
      M_HUNT: begin
        if (m != '0) begin
          for (int i = 2*W-1; i >= 0; i--) if (m[i]) cap = i;
          wc = 0; hits = 0; mode = M_VERIFY;
        end
      end
      M_VERIFY: begin
        wc = (wc + 1) % FW;
        if (wc == 0) begin
          if (m[cap]) begin
            hits++;
            if (hits == CONFIRM) begin mode = M_LOCKED; misses = 0; end
          end else begin
            mode = M_HUNT;
          end
        end
      end
      default: begin
        shifted   = win >> (cap % W);
        exp_valid = 1'b1;
        exp_data  = shifted[W-1:0];
        exp_sof   = (wc == 0);
        wc = (wc + 1) % FW;
        if (wc == 0) begin
          if (m[cap]) misses = 0;
          else begin
            misses++;
            if (misses == MISS_LIMIT) begin mode = M_HUNT; exp_lost = 1'b1; end
          end
        end
      end
    endcase
  endtask

  // Drives one clock cycle; masks on non-evaluation cycles are random garbage that must be ignored.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic [2*W-1:0] m);
    @(negedge clk);
    nrst      = 1'b1;
    in_valid  = v;
    in_data   = d;
    sync_mask = prev_valid ? m : (2*W)'($urandom);
    exp_valid = 1'b0; exp_sof = 1'b0; exp_lost = 1'b0;
    if (prev_valid) modelEval(m);
    if (v) begin
      hist.push_back(d);
      if (hist.size() > 2) void'(hist.pop_front());
    end
    prev_valid = v;
    @(posedge clk); #1;
    compareAll();
  endtask

  task automatic doReset();
    @(negedge clk);
    nrst = 1'b0; in_valid = 1'b0; in_data = '0; sync_mask = '0;
    prev_valid = 1'b0; hist.delete();
    mode = M_HUNT; wc = 0; cap = 0; hits = 0; misses = 0;
    exp_valid = 1'b0; exp_sof = 1'b0; exp_lost = 1'b0; exp_data = '0;
    @(posedge clk); #1;
    compareAll();
  endtask

  task automatic evalMask(input logic [2*W-1:0] m);
    applyStimulus(1'b1, W'($urandom), m);
  endtask

  // One evaluation whose mask carries the captured bit only when it lands on the expected slot and hit is set.
  task automatic evalSlot(input bit hit);
    logic [2*W-1:0] m;
    m = '0;
    if (mode != M_HUNT && wc == FW-1 && hit) m[cap] = 1'b1;
    evalMask(m);
  endtask

  task automatic lockUp(input logic [2*W-1:0] m);
    evalMask(m);
    repeat (CONFIRM*FW) evalSlot(1'b1);
  endtask

  initial begin
    logic           v;
    logic [2*W-1:0] m;

    doReset();
    applyStimulus(1'b1, 8'hA5, '0);

    // Capture at bit 11, confirm twice, then run locked frames.
    lockUp(16'h0800);
    repeat (2*FW) evalSlot(1'b1);

    // Two consecutive misses drop lock, then a fresh capture restarts verification.
    repeat (2*FW) evalSlot(1'b0);
    evalMask(16'h0800);
    repeat (FW) evalSlot(1'b1);

    // Two simultaneous bits capture the lower one; a hit elsewhere on the slot is a miss.
    doReset();
    applyStimulus(1'b1, 8'h3C, '0);
    evalMask(16'h0024);
    repeat (FW-2) evalSlot(1'b0);
    evalMask(16'h0020);
    evalMask(16'h0000);

    // Miss, hit, miss, hit never reaches the miss limit.
    lockUp(16'h0100);
    repeat (FW) evalSlot(1'b0);
    repeat (FW) evalSlot(1'b1);
    repeat (FW) evalSlot(1'b0);
    repeat (FW) evalSlot(1'b1);

    // Input gap mid-frame stalls everything.
    repeat (2) evalSlot(1'b1);
    repeat (5) applyStimulus(1'b0, W'($urandom), (2*W)'($urandom));
    repeat (2*FW) evalSlot(1'b1);

    // Reset while locked discards alignment until a new lock.
    doReset();
    applyStimulus(1'b1, 8'h5A, '0);
    repeat (3) evalSlot(1'b1);
    lockUp(16'h8000);
    repeat (FW) evalSlot(1'b1);

    // Random traffic with gaps, mostly-correct syncs and occasional stray mask bits.
    doReset();
    for (int n = 0; n < 800; n++) begin
      v = ($urandom_range(3) != 0);
      m = '0;
      if (prev_valid && mode != M_HUNT && wc == FW-1) begin
        if ($urandom_range(9) < 8) m[cap] = 1'b1;
      end else if ($urandom_range(11) == 0) begin
        m[$urandom_range(2*W-1)] = 1'b1;
      end
      applyStimulus(v, W'($urandom), m);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
